// File: rtl/ps2_kb_writer_if.sv
// Keyboard-side write port into the memory map.
// The writer drives it; the memory map consumes it.
interface ps2_kb_writer_if;
   logic [31:0] kb_wraddr;
   logic [31:0] kb_wrdata;
   logic        kb_we;

   modport master (
      output kb_wraddr,
      output kb_wrdata,
      output kb_we
   );

   modport slave (
      input kb_wraddr,
      input kb_wrdata,
      input kb_we
   );
endinterface

// File: rtl/ps2_kb_writer.sv
// PS/2 keyboard deframer: folds E0/F0 prefixes into key events,
// tracks modifiers and writes one status word per event.
module ps2_kb_writer #(
   parameter logic [31:0] KB_INFO_OFFSET = 32'h0050_0000,
   parameter logic [31:0] TIMEOUT        = 32'd50000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ps2_clk,
   input  logic            ps2_data,
   ps2_kb_writer_if.master wr
);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      CHECK
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  clk_sync_q;
   logic [1:0]  dat_sync_q;
   logic [3:0]  cnt_q, cnt_d;
   logic [9:0]  sh_q, sh_d;
   logic [31:0] tmo_q, tmo_d;
   logic        ext_q, ext_d;
   logic        brk_q, brk_d;
   logic        shift_q, shift_d;
   logic        ctrl_q, ctrl_d;
   logic        caps_q, caps_d;
   logic        held_q, held_d;
   logic [7:0]  seq_q, seq_d;
   logic [31:0] data_q, data_d;
   logic        we_q, we_d;

   logic        fall;
   logic        bit_in;
   logic        frame_ok;
   logic [7:0]  code;
   logic        is_shift;

   // [2] is the previous value of the second sync stage
   assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
   assign bit_in = dat_sync_q[1];

   // sh_q: [7:0] data, [8] parity, [9] stop
   assign code     = sh_q[7:0];
   assign frame_ok = (^sh_q[8:0]) & sh_q[9];
   assign is_shift = (code == 8'h12) || (code == 8'h59);

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q <= 3'b111;
         dat_sync_q <= 2'b11;
         state_q    <= IDLE;
         cnt_q      <= '0;
         sh_q       <= '0;
         tmo_q      <= '0;
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         shift_q    <= 1'b0;
         ctrl_q     <= 1'b0;
         caps_q     <= 1'b0;
         held_q     <= 1'b0;
         seq_q      <= '0;
         data_q     <= '0;
         we_q       <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
         dat_sync_q <= {dat_sync_q[0], ps2_data};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         tmo_q      <= tmo_d;
         ext_q      <= ext_d;
         brk_q      <= brk_d;
         shift_q    <= shift_d;
         ctrl_q     <= ctrl_d;
         caps_q     <= caps_d;
         held_q     <= held_d;
         seq_q      <= seq_d;
         data_q     <= data_d;
         we_q       <= we_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      tmo_d   = tmo_q;
      ext_d   = ext_q;
      brk_d   = brk_q;
      shift_d = shift_q;
      ctrl_d  = ctrl_q;
      caps_d  = caps_q;
      held_d  = held_q;
      seq_d   = seq_q;
      data_d  = data_q;
      we_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (fall && !bit_in) begin
               state_d = RECV;
               cnt_d   = '0;
            end
         end
         RECV: begin
            if (fall) begin
               sh_d  = {bit_in, sh_q[9:1]};
               cnt_d = cnt_q + 4'd1;
               tmo_d = '0;
               if (cnt_q == 4'd9) state_d = CHECK;
            end else if (tmo_q == TIMEOUT) begin
               state_d = IDLE;
               tmo_d   = '0;
               ext_d   = 1'b0;
               brk_d   = 1'b0;
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
         end
         CHECK: begin
            state_d = IDLE;
            if (!frame_ok) begin
               ext_d = 1'b0;
               brk_d = 1'b0;
            end else begin
               unique case (code)
                  8'hE0: ext_d = 1'b1;
                  8'hF0: brk_d = 1'b1;
                  default: begin
                     ext_d = 1'b0;
                     brk_d = 1'b0;
                     // make needs a plain code, any break releases
                     if (is_shift && (brk_q || !ext_q))
                        shift_d = !brk_q;
                     if (code == 8'h14)
                        ctrl_d = !brk_q;
                     if (code == 8'h58) begin
                        if (brk_q) begin
                           held_d = 1'b0;
                        end else if (!ext_q) begin
                           if (!held_q) caps_d = !caps_q;
                           held_d = 1'b1;
                        end
                     end
                     seq_d  = seq_q + 8'd1;
                     data_d = {seq_d, 3'b000,
                               caps_d, ctrl_d, shift_d,
                               ext_q, brk_q,
                               8'h00, code};
                     we_d   = 1'b1;
                  end
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr.kb_wraddr = KB_INFO_OFFSET;
   assign wr.kb_wrdata = data_q;
   assign wr.kb_we     = we_q;

endmodule

// File: tb/tb_ps2_kb_writer.sv
// Bench for ps2_kb_writer: constant vectors, corner sequences
// and random frames against an event-level keyboard model.
module tb_ps2_kb_writer;
   localparam int TMO = 200;

   logic clk = 1'b0;
   logic rst;
   logic ps2_clk;
   logic ps2_data;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_tot = 0;
   int   stop_cyc = 0;

   ps2_kb_writer_if wr ();

   ps2_kb_writer #(
      .KB_INFO_OFFSET(32'h0050_0000),
      .TIMEOUT       (TMO)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .wr      (wr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] d;
      int          c;
   } wr_t;
   wr_t wq[$];

   always @(negedge clk)
      if (wr.kb_we === 1'b1) wq.push_back('{wr.kb_wrdata, cyc});

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1);
   end

   // event-level keyboard model
   bit       m_ext, m_brk, m_shift, m_ctrl, m_caps, m_held;
   bit [7:0] m_seq;

   task automatic m_reset();
      {m_ext, m_brk, m_shift, m_ctrl, m_caps, m_held} = '0;
      m_seq = 8'd0;
   endtask

   task automatic model(input logic [7:0] c, input bit bad,
                        output bit ev, output logic [31:0] w);
      bit e, b;
      ev = 0;
      w  = '0;
      if (bad) begin
         m_ext = 0;
         m_brk = 0;
         return;
      end
      if (c == 8'hE0) begin
         m_ext = 1;
         return;
      end
      if (c == 8'hF0) begin
         m_brk = 1;
         return;
      end
      e = m_ext;
      b = m_brk;
      m_ext = 0;
      m_brk = 0;
      if (c == 8'h12 || c == 8'h59) begin
         if (b) m_shift = 0;
         else if (!e) m_shift = 1;
      end
      if (c == 8'h14) m_ctrl = !b;
      if (c == 8'h58) begin
         if (b) m_held = 0;
         else if (!e) begin
            if (!m_held) m_caps = !m_caps;
            m_held = 1;
         end
      end
      m_seq = m_seq + 8'd1;
      w = {m_seq, 3'b000, m_caps, m_ctrl, m_shift, e, b, 8'h00, c};
      ev = 1;
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] frame(logic [7:0] c, bit bp, bit bs);
      return {~bs, (~^c) ^ bp, c, 1'b0};
   endfunction

   task automatic send_bits(logic [10:0] f, int nbits, int hp);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         tick(hp);
         ps2_clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         tick(hp);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic run_frame(string nm, logic [7:0] c, bit bp, bit bs,
                            int hp, bit ew, logic [31:0] ed);
      logic [31:0] prev;
      prev = wr.kb_wrdata;
      wq.delete();
      send_bits(frame(c, bp, bs), 11, hp);
      tick(6);
      chk({nm, " writes"}, wq.size(), {31'd0, ew});
      if (ew && wq.size() == 1) begin
         chk({nm, " data"}, wq[0].d, ed);
         chk({nm, " latency"}, wq[0].c - stop_cyc, 4);
         chk({nm, " addr"}, wr.kb_wraddr, 32'h0050_0000);
      end else if (!ew) begin
         chk({nm, " held"}, wr.kb_wrdata, prev);
      end
   endtask

   task automatic model_frame(string nm, logic [7:0] c, bit bp, bit bs,
                              int hp);
      bit          ev;
      logic [31:0] w;
      model(c, bp | bs, ev, w);
      run_frame(nm, c, bp, bs, hp, ev, w);
   endtask

   typedef struct {
      logic [7:0]  c;
      bit          bp;
      bit          bs;
      bit          ew;
      logic [31:0] ed;
   } vec_t;
   vec_t tab[$];

   initial begin
      bit          ev;
      logic [31:0] w;
      logic [7:0]  pool [10];

      tab.push_back('{8'h1C, 0, 0, 1, 32'h0100_001C});
      tab.push_back('{8'hF0, 0, 0, 0, 32'h0});
      tab.push_back('{8'h1C, 0, 0, 1, 32'h0201_001C});
      tab.push_back('{8'hE0, 0, 0, 0, 32'h0});
      tab.push_back('{8'h74, 0, 0, 1, 32'h0302_0074});
      tab.push_back('{8'hE0, 0, 0, 0, 32'h0});
      tab.push_back('{8'hF0, 0, 0, 0, 32'h0});
      tab.push_back('{8'h74, 0, 0, 1, 32'h0403_0074});
      tab.push_back('{8'h12, 0, 0, 1, 32'h0504_0012});
      tab.push_back('{8'h58, 0, 0, 1, 32'h0614_0058});
      tab.push_back('{8'h58, 0, 0, 1, 32'h0714_0058});
      tab.push_back('{8'hF0, 0, 0, 0, 32'h0});
      tab.push_back('{8'h58, 0, 0, 1, 32'h0815_0058});
      tab.push_back('{8'h58, 0, 0, 1, 32'h0904_0058});
      tab.push_back('{8'hF0, 0, 0, 0, 32'h0});
      tab.push_back('{8'h12, 0, 0, 1, 32'h0A01_0012});
      tab.push_back('{8'h1C, 1, 0, 0, 32'h0});
      tab.push_back('{8'hF0, 0, 0, 0, 32'h0});
      tab.push_back('{8'h1C, 1, 0, 0, 32'h0});
      tab.push_back('{8'h1C, 0, 0, 1, 32'h0B00_001C});
      tab.push_back('{8'hF0, 0, 0, 0, 32'h0});
      tab.push_back('{8'h1C, 0, 1, 0, 32'h0});
      tab.push_back('{8'h1C, 0, 0, 1, 32'h0C00_001C});

      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rst      = 1'b1;
      m_reset();
      tick(3);
      chk("reset we", {31'd0, wr.kb_we}, 32'd0);
      chk("reset data", wr.kb_wrdata, 32'd0);
      chk("reset addr", wr.kb_wraddr, 32'h0050_0000);
      rst = 1'b0;
      tick(3);

      foreach (tab[i]) begin
         model(tab[i].c, tab[i].bp | tab[i].bs, ev, w);
         run_frame($sformatf("vec%0d", i), tab[i].c, tab[i].bp,
                   tab[i].bs, 4, tab[i].ew, tab[i].ed);
      end

      // partial frame abandoned by timeout, pending F0 dropped
      model_frame("to_f0", 8'hF0, 0, 0, 3);
      send_bits(frame(8'h1C, 0, 0), 5, 3);
      tick(TMO + 40);
      m_ext = 0;
      m_brk = 0;
      model_frame("to_1c", 8'h1C, 0, 0, 3);

      // reset sampled in the cycle the write would have appeared
      wq.delete();
      send_bits(frame(8'h1C, 0, 0), 10, 3);
      ps2_data = 1'b1;
      tick(3);
      ps2_clk = 1'b0;
      stop_cyc = cyc;
      tick(3);
      rst = 1'b1;
      tick(1);
      chk("rst_evt we", {31'd0, wr.kb_we}, 32'd0);
      chk("rst_evt data", wr.kb_wrdata, 32'd0);
      tick(1);
      rst = 1'b0;
      ps2_clk = 1'b1;
      tick(4);
      chk("rst_evt writes", wq.size(), 32'd0);
      m_reset();

      // reset mid-frame with a pending F0
      model_frame("rm_f0", 8'hF0, 0, 0, 3);
      send_bits(frame(8'h74, 0, 0), 5, 3);
      rst = 1'b1;
      tick(1);
      chk("rst_mid we", {31'd0, wr.kb_we}, 32'd0);
      chk("rst_mid data", wr.kb_wrdata, 32'd0);
      tick(1);
      rst = 1'b0;
      tick(3);
      m_reset();
      run_frame("rm_1c", 8'h1C, 0, 0, 3, 1, 32'h0100_001C);
      model(8'h1C, 0, ev, w);

      // random traffic, long enough to wrap seq
      pool = '{8'h12, 8'h59, 8'h14, 8'h58, 8'h1C,
               8'h74, 8'hE0, 8'hF0, 8'h29, 8'h00};
      for (int i = 0; i < 420; i++) begin
         int          k;
         logic [7:0]  c;
         bit          bp, bs;
         k  = $urandom_range(0, 11);
         c  = (k >= 9) ? 8'($urandom_range(0, 255)) : pool[k];
         bp = ($urandom_range(0, 9) == 0);
         bs = ($urandom_range(0, 19) == 0);
         model_frame($sformatf("rnd%0d", i), c, bp, bs,
                     $urandom_range(2, 3));
         tick($urandom_range(0, 4));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
